// File: rtl/rob_retire_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rob_retire_pkg
// Brief   : Shared ROB sizing, tag type and entry layout (also used by commit).
// Revision: 1.0
// ============================================================================
package rob_retire_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = $clog2(ROB_DEPTH + 1);
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;
    localparam int IDX_W     = $clog2(ROB_DEPTH);
    localparam int PTR_W     = IDX_W + 1;

    typedef logic [TAG_W-1:0] rob_tag_t;

    localparam rob_tag_t NO_TAG = '0;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic              regwr;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_retire_ptr.sv
`default_nettype none
// ============================================================================
// Module  : rob_ptr
// Brief   : Wrap-bit pointer counter (index plus one extra MSB) with clear.
// Revision: 1.0
// ============================================================================
module rob_ptr #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Natural overflow of PTR_W bits gives the modulo 2*depth wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/rob_retire.sv
`default_nettype none
// ============================================================================
// Module  : rob_retire
// Brief   : Reorder buffer storage with tag allocation and in-order retirement.
// Revision: 1.0
// ============================================================================
module rob_retire
    import rob_retire_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic              alloc_regwr,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output rob_tag_t          alloc_tag,
    input  logic              complete_valid,
    input  rob_tag_t          complete_tag,
    input  logic [DATA_W-1:0] complete_value,
    output logic              retire_valid,
    output logic              retire_regwr,
    output logic [REG_W-1:0]  retire_dest,
    output logic [DATA_W-1:0] retire_value,
    output rob_tag_t          retire_tag,
    output rob_tag_t          count
);

    logic [PTR_W-1:0]  w_head;
    logic [PTR_W-1:0]  w_tail;
    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic              w_full;
    logic              w_do_alloc;
    logic              w_do_retire;
    rob_entry_t        w_entries [ROB_DEPTH];
    rob_entry_t        w_head_entry;

    logic              r_retire_valid;
    logic              r_retire_regwr;
    logic [REG_W-1:0]  r_retire_dest;
    logic [DATA_W-1:0] r_retire_value;
    rob_tag_t          r_retire_tag;

    rob_ptr #(.PTR_W(PTR_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .i_clr (flush),
        .i_inc (w_do_retire),
        .o_ptr (w_head)
    );

    rob_ptr #(.PTR_W(PTR_W)) u_tail (
        .clk   (clk),
        .reset (reset),
        .i_clr (flush),
        .i_inc (w_do_alloc),
        .o_ptr (w_tail)
    );

    assign w_head_idx   = w_head[IDX_W-1:0];
    assign w_tail_idx   = w_tail[IDX_W-1:0];
    assign w_full       = (w_head_idx == w_tail_idx) && (w_head[PTR_W-1] != w_tail[PTR_W-1]);
    assign w_head_entry = w_entries[w_head_idx];
    assign w_do_alloc   = alloc_valid && !w_full && !flush;
    assign w_do_retire  = w_head_entry.valid && w_head_entry.ready && !flush;

    assign alloc_ready  = !w_full;
    assign alloc_tag    = TAG_W'(w_tail_idx) + TAG_W'(1);
    assign count        = TAG_W'(w_tail - w_head);

    // The tail slot is never valid while not full, so alloc and completion
    // cannot collide; alloc and retire on one slot would need a full buffer.
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
        rob_entry_t r_entry;
        logic       w_alloc_hit;
        logic       w_cmp_hit;
        logic       w_ret_hit;

        assign w_alloc_hit = w_do_alloc && (w_tail_idx == IDX_W'(gi));
        assign w_cmp_hit   = complete_valid && (complete_tag == TAG_W'(gi + 1)) && r_entry.valid;
        assign w_ret_hit   = w_do_retire && (w_head_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_entry <= '0;
            end else if (flush) begin
                r_entry.valid <= 1'b0;
                r_entry.ready <= 1'b0;
            end else if (w_ret_hit) begin
                r_entry.valid <= 1'b0;
                r_entry.ready <= 1'b0;
            end else if (w_alloc_hit) begin
                r_entry.valid <= 1'b1;
                r_entry.ready <= 1'b0;
                r_entry.regwr <= alloc_regwr;
                r_entry.dest  <= alloc_dest;
                r_entry.value <= '0;
            end else if (w_cmp_hit) begin
                r_entry.ready <= 1'b1;
                r_entry.value <= complete_value;
            end
        end

        assign w_entries[gi] = r_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_valid <= 1'b0;
            r_retire_regwr <= 1'b0;
            r_retire_dest  <= '0;
            r_retire_value <= '0;
            r_retire_tag   <= NO_TAG;
        end else if (w_do_retire) begin
            r_retire_valid <= 1'b1;
            r_retire_regwr <= w_head_entry.regwr;
            r_retire_dest  <= w_head_entry.dest;
            r_retire_value <= w_head_entry.value;
            r_retire_tag   <= TAG_W'(w_head_idx) + TAG_W'(1);
        end else begin
            r_retire_valid <= 1'b0;
        end
    end

    assign retire_valid = r_retire_valid;
    assign retire_regwr = r_retire_regwr;
    assign retire_dest  = r_retire_dest;
    assign retire_value = r_retire_value;
    assign retire_tag   = r_retire_tag;

endmodule
`default_nettype wire

// File: tb/tb_rob_retire.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_retire
// Brief   : Randomized scoreboard bench for rob_retire against a queue model.
// Revision: 1.0
// ============================================================================
module tb_rob_retire;
    import rob_retire_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              alloc_valid = 1'b0;
    logic              alloc_regwr = 1'b0;
    logic [REG_W-1:0]  alloc_dest = '0;
    logic              alloc_ready;
    rob_tag_t          alloc_tag;
    logic              complete_valid = 1'b0;
    rob_tag_t          complete_tag = '0;
    logic [DATA_W-1:0] complete_value = '0;
    logic              retire_valid;
    logic              retire_regwr;
    logic [REG_W-1:0]  retire_dest;
    logic [DATA_W-1:0] retire_value;
    rob_tag_t          retire_tag;
    rob_tag_t          count;

    rob_retire dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .alloc_valid    (alloc_valid),
        .alloc_regwr    (alloc_regwr),
        .alloc_dest     (alloc_dest),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .complete_valid (complete_valid),
        .complete_tag   (complete_tag),
        .complete_value (complete_value),
        .retire_valid   (retire_valid),
        .retire_regwr   (retire_regwr),
        .retire_dest    (retire_dest),
        .retire_value   (retire_value),
        .retire_tag     (retire_tag),
        .count          (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        bit          regwr;
        int          dest;
        logic [31:0] value;
        bit          ready;
    } m_ent_t;

    typedef struct {
        int          edge_no;
        int          tag;
        bit          regwr;
        int          dest;
        logic [31:0] value;
    } exp_t;

    m_ent_t rob_q[$];
    exp_t   exp_q[$];
    int     next_tag = 1;
    int     edge_cnt = 0;
    int     checks = 0;
    int     failures = 0;

    always @(posedge clk) edge_cnt++;

    // Monitor: every falling edge compares the retire port to the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_v;
        while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL retire_missing tag=%0d edge=%0d now=%0d", e.tag, e.edge_no, edge_cnt);
        end
        exp_v = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_cnt);
        checks++;
        if (retire_valid !== exp_v) begin
            failures++;
            $display("FAIL retire_valid edge=%0d got=%0b want=%0b", edge_cnt, retire_valid, exp_v);
            if (exp_v) void'(exp_q.pop_front());
        end else if (exp_v) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(retire_tag) != e.tag || retire_regwr !== e.regwr ||
                int'(retire_dest) != e.dest || retire_value !== e.value) begin
                failures++;
                $display("FAIL retire_fields edge=%0d got tag=%0d regwr=%0b dest=%0d val=%h want tag=%0d regwr=%0b dest=%0d val=%h",
                         edge_cnt, retire_tag, retire_regwr, retire_dest, retire_value,
                         e.tag, e.regwr, e.dest, e.value);
            end
        end
    end

    task automatic check_state(input string name);
        checks++;
        if (int'(count) != rob_q.size() || alloc_ready !== (rob_q.size() < ROB_DEPTH) ||
            (rob_q.size() < ROB_DEPTH && int'(alloc_tag) != next_tag)) begin
            failures++;
            $display("FAIL %s got count=%0d ready=%0b tag=%0d want count=%0d ready=%0b tag=%0d",
                     name, count, alloc_ready, alloc_tag, rob_q.size(),
                     rob_q.size() < ROB_DEPTH, next_tag);
        end
    endtask

    // Drive one edge worth of inputs and advance the model by the same edge.
    task automatic step(input bit av, input bit rw, input int dst, input bit cv,
                        input int ctag, input logic [31:0] cval, input bit fl);
        bit     pre_full;
        m_ent_t m;
        exp_t   e;
        alloc_valid    = av;
        alloc_regwr    = rw;
        alloc_dest     = REG_W'(dst);
        complete_valid = cv;
        complete_tag   = TAG_W'(ctag);
        complete_value = cval;
        flush          = fl;
        pre_full = (rob_q.size() == ROB_DEPTH);
        if (fl) begin
            rob_q.delete();
            next_tag = 1;
        end else begin
            if (rob_q.size() > 0 && rob_q[0].ready) begin
                m = rob_q.pop_front();
                e.edge_no = edge_cnt + 1;
                e.tag = m.tag; e.regwr = m.regwr; e.dest = m.dest; e.value = m.value;
                exp_q.push_back(e);
            end
            if (cv && ctag != 0) begin
                foreach (rob_q[i]) if (rob_q[i].tag == ctag) begin
                    rob_q[i].ready = 1'b1;
                    rob_q[i].value = cval;
                end
            end
            if (av && !pre_full) begin
                m.tag = next_tag; m.regwr = rw; m.dest = dst; m.value = '0; m.ready = 1'b0;
                rob_q.push_back(m);
                next_tag = (next_tag == ROB_DEPTH) ? 1 : next_tag + 1;
            end
        end
        @(posedge clk);
        #1;
        alloc_valid = 1'b0; complete_valid = 1'b0; flush = 1'b0;
        check_state("state");
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (retire_valid !== 1'b0 || retire_regwr !== 1'b0 || retire_dest !== '0 ||
            retire_value !== '0 || retire_tag !== '0 || count !== '0 ||
            alloc_ready !== 1'b1 || alloc_tag !== TAG_W'(1)) begin
            failures++;
            $display("FAIL %s got rv=%0b rw=%0b rd=%0d val=%h rt=%0d cnt=%0d ar=%0b at=%0d want zeros, ready=1 tag=1",
                     name, retire_valid, retire_regwr, retire_dest, retire_value,
                     retire_tag, count, alloc_ready, alloc_tag);
        end
    endtask

    initial begin
        int ctag;
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Three allocations, then out-of-order completion.
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 32'hBEEF, 0);
        step(0, 0, 0, 1, 1, 32'h1234, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Fill to full, push against full, then free one slot.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < ROB_DEPTH + 2; i++) step(1, 1, i % 32, 0, 0, 0, 0);
        step(1, 1, 7, 1, 1, 32'hCAFE, 0);
        step(1, 0, 9, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Completions that must be ignored.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, i, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h1111, 0);
        step(0, 0, 0, 1, 5, 32'h2222, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Flush on the edge where tag 1 would retire.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, i + 4, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h5555, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // regwr=0 entry retires, then reset lands with a retire pending.
        step(1, 0, 12, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'hA5A5_0001, 0);
        step(1, 1, 13, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 32'h7777, 0);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset_midstream");
        rob_q.delete();
        exp_q.delete();
        next_tag = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_state("after_reset");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (rob_q.size() > 0 && ($urandom % 4) != 0)
                ctag = rob_q[$urandom % rob_q.size()].tag;
            else
                ctag = int'($urandom % (ROB_DEPTH + 1));
            step(($urandom % 100) < 55, $urandom % 2, int'($urandom % 32),
                 ($urandom % 100) < 60, ctag, $urandom, ($urandom % 150) == 0);
        end
        for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0, 0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
